// File: rtl/w_schedule_stream.sv
// SHA-256 message-schedule expander with valid/ready flow control.
// It loads one 512-bit block (W0..W15) into a 16-word sliding window.
// It then streams W0..W(ROUNDS-1), LANES words per beat.
// The window slides down by LANES on each accepted beat. The vacated top
// slots are refilled with freshly expanded words, chained combinationally
// so that lane j can depend on lanes j-2 and below from the same cycle.
// Legal configurations: LANES in {1,2,4,8}, ROUNDS a multiple of LANES,
// 16 <= ROUNDS <= 64.
module w_schedule_stream #(
    parameter int LANES  = 1,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [511:0]          in_block,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   out_w,
    output logic [6:0]            out_index,
    output logic                  out_last
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - LANES);
    localparam logic [6:0] STEP     = 7'(LANES);

    state_t              state_q, state_d;
    logic [511:0]        win_q, win_d;
    logic [6:0]          idx_q, idx_d;
    logic [LANES*32-1:0] new_words;
    logic                is_last;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // x[0..15] is the current window.
    // x[16+j] is the j-th new word, computed in order so later lanes see
    // earlier ones.
    function automatic logic [LANES*32-1:0] expand(input logic [511:0] win);
        logic [31:0]         x [16+LANES];
        logic [LANES*32-1:0] n;
        for (int k = 0; k < 16; k++) begin
            x[k] = win[k*32 +: 32];
        end
        for (int j = 0; j < LANES; j++) begin
            x[16+j] = '0;
        end
        n = '0;
        for (int j = 0; j < LANES; j++) begin
            x[16+j] = sig1(x[14+j]) + x[9+j] + sig0(x[1+j]) + x[j];
            n[j*32 +: 32] = x[16+j];
        end
        return n;
    endfunction

    // Output view of the window and handshake flags.
    always_comb begin
        new_words = expand(win_q);
        is_last   = (idx_q == LAST_IDX);
        in_ready  = reset && (state_q == S_IDLE);
        out_valid = (state_q == S_RUN);
        out_last  = (state_q == S_RUN) && is_last;
        out_w     = win_q[LANES*32-1:0];
        out_index = idx_q;
    end

    // Next-state logic: load on accept, slide on every consumed non-final beat.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    win_d   = in_block;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = S_IDLE;
                    end else begin
                        win_d = {new_words, win_q[511:LANES*32]};
                        idx_d = idx_q + STEP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, window and index registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_w_schedule_stream.sv
// Bench for w_schedule_stream.
// Two instances, LANES=1 and LANES=4, share the block bus and the reset.
// Expected words come from a plain sequential SHA-256 schedule model.
// They are queued at block accept and checked beat by beat.
module tb_w_schedule_stream;

    localparam int ROUNDS = 64;

    typedef struct {
        int          idx;
        logic [31:0] w;
    } exp_t;

    typedef struct {
        int          d;
        int          idx;
        logic [31:0] w;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] in_block;
    logic [1:0]   iv, ordy;
    logic         ir0, ir1, ov0, ov1, ol0, ol1;
    logic [6:0]   oidx0, oidx1;
    logic [31:0]  ow0;
    logic [127:0] ow1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t        sbq0[$];
    exp_t        sbq1[$];
    logic [31:0] ref_w [64];
    logic [31:0] got   [2][64];
    vec_t        vecs  [10];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    w_schedule_stream #(.LANES(1), .ROUNDS(ROUNDS)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir0), .in_block(in_block),
        .out_valid(ov0), .out_ready(ordy[0]), .out_w(ow0), .out_index(oidx0), .out_last(ol0)
    );

    w_schedule_stream #(.LANES(4), .ROUNDS(ROUNDS)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1), .in_block(in_block),
        .out_valid(ov1), .out_ready(ordy[1]), .out_w(ow1), .out_index(oidx1), .out_last(ol1)
    );

    function automatic logic f_ir(input int d);
        return (d != 0) ? ir1 : ir0;
    endfunction

    function automatic logic f_ov(input int d);
        return (d != 0) ? ov1 : ov0;
    endfunction

    function automatic logic f_ol(input int d);
        return (d != 0) ? ol1 : ol0;
    endfunction

    function automatic logic [6:0] f_idx(input int d);
        return (d != 0) ? oidx1 : oidx0;
    endfunction

    function automatic logic [127:0] f_w(input int d);
        return (d != 0) ? ow1 : {96'b0, ow0};
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic make_ref(input logic [511:0] blk);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) ref_w[i] = blk[i*32 +: 32];
            else ref_w[i] = ms1(ref_w[i-2]) + ref_w[i-7] + ms0(ref_w[i-15]) + ref_w[i-16];
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_block(output logic [511:0] blk);
        for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom;
    endtask

    // Present one block to instance d, then drain it through the scoreboard.
    // hold keeps in_valid high after accept, showing hold_blk during the run.
    // rnd toggles out_ready randomly.
    task automatic run_block(input int d, input logic [511:0] blk, input logic [511:0] hold_blk,
                             input bit hold, input bit rnd, output int first_cyc);
        int           l;
        int           budget;
        int           sz;
        bit           accepted, done, seen, stalled, just_acc;
        logic [6:0]   s_idx;
        logic [127:0] s_w;
        logic [127:0] w;
        exp_t         e;
        l = (d != 0) ? 4 : 1;
        accepted = 0; done = 0; seen = 0; stalled = 0; just_acc = 0;
        budget = 0; first_cyc = -1; s_idx = '0; s_w = '0;
        while (!done && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (!accepted) begin
                in_block = blk;
                iv[d] = 1'b1;
            end else begin
                iv[d] = hold;
                if (hold) in_block = hold_blk;
            end
            ordy[d] = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (just_acc) chk("load_latency", f_ov(d), 1);
            just_acc = 0;
            if (stalled) begin
                chk("stall_valid", f_ov(d), 1);
                chk("stall_index", f_idx(d), s_idx);
                chk("stall_w", f_w(d), s_w);
            end
            stalled = 0;
            if (f_ov(d)) begin
                if (!seen) begin
                    seen = 1;
                    first_cyc = cyc;
                end
                if (ordy[d]) begin
                    w = f_w(d);
                    for (int j = 0; j < l; j++) begin
                        sz = (d != 0) ? sbq1.size() : sbq0.size();
                        if (sz == 0) begin
                            chk("sb_underflow", sz, 1);
                        end else begin
                            if (d != 0) e = sbq1.pop_front();
                            else e = sbq0.pop_front();
                            if (j == 0) begin
                                chk("out_index", f_idx(d), e.idx);
                                chk("out_last", f_ol(d), (e.idx == ROUNDS - l));
                                if (e.idx == ROUNDS - l) done = 1;
                            end
                            chk("out_w", w[j*32 +: 32], e.w);
                            got[d][e.idx] = w[j*32 +: 32];
                        end
                    end
                end else begin
                    stalled = 1;
                    s_idx = f_idx(d);
                    s_w = f_w(d);
                end
            end
            if (!accepted && f_ir(d)) begin
                accepted = 1;
                just_acc = 1;
                make_ref(blk);
                for (int i = 0; i < ROUNDS; i++) begin
                    e.idx = i;
                    e.w = ref_w[i];
                    if (d != 0) sbq1.push_back(e);
                    else sbq0.push_back(e);
                end
            end
            @(posedge clk);
        end
        chk("block_complete", done, 1);
    endtask

    initial begin
        logic [511:0] abc, blk_a, blk_b, zero;
        int           fc1, fc2, mism, n;

        vecs[0] = '{0, 0,  32'h61626380};
        vecs[1] = '{0, 15, 32'h00000018};
        vecs[2] = '{0, 16, 32'h61626380};
        vecs[3] = '{0, 17, 32'h000F0000};
        vecs[4] = '{0, 18, 32'h7DA86405};
        vecs[5] = '{1, 0,  32'h61626380};
        vecs[6] = '{1, 16, 32'h61626380};
        vecs[7] = '{1, 17, 32'h000F0000};
        vecs[8] = '{1, 18, 32'h7DA86405};
        vecs[9] = '{1, 19, 32'h600003C6};

        abc = '0;
        abc[31:0] = 32'h61626380;
        abc[15*32 +: 32] = 32'h00000018;
        zero = '0;

        reset = 1'b0; iv = '0; ordy = '0; in_block = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid_l1", ov0, 0);
        chk("rst_ready_l1", ir0, 0);
        chk("rst_index_l1", oidx0, 0);
        chk("rst_last_l1", ol0, 0);
        chk("rst_w_l1", ow0, 0);
        chk("rst_valid_l4", ov1, 0);
        chk("rst_ready_l4", ir1, 0);
        chk("rst_w_l4", ow1, 0);
        reset = 1'b1;
        #1;
        chk("rel_ready_l1", ir0, 1);
        chk("rel_ready_l4", ir1, 1);

        run_block(0, abc, zero, 0, 0, fc1);
        @(negedge clk);
        chk("after_last_ready", ir0, 1);
        chk("after_last_valid", ov0, 0);
        run_block(1, abc, zero, 0, 0, fc1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("abc_w%0d_lanes%0d", vecs[i].idx, (vecs[i].d != 0) ? 4 : 1),
                got[vecs[i].d][vecs[i].idx], vecs[i].w);
        end
        mism = 0;
        for (int i = 0; i < 64; i++) if (got[0][i] !== got[1][i]) mism++;
        chk("lane_stream_equal", mism, 0);

        for (int k = 0; k < 3; k++) begin
            rand_block(blk_a);
            run_block(0, blk_a, zero, 0, 1, fc1);
            rand_block(blk_a);
            run_block(1, blk_a, zero, 0, 1, fc1);
        end

        rand_block(blk_b);
        run_block(0, zero, blk_b, 1, 0, fc1);
        run_block(0, blk_b, zero, 0, 0, fc2);
        chk("b2b_period_l1", fc2 - fc1, 65);
        rand_block(blk_b);
        run_block(1, zero, blk_b, 1, 0, fc1);
        run_block(1, blk_b, zero, 0, 0, fc2);
        chk("b2b_period_l4", fc2 - fc1, 17);

        rand_block(blk_a);
        @(negedge clk);
        iv = '0;
        in_block = blk_a;
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        n = 0;
        while (oidx0 != 7'd20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx20", oidx0, 20);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", ov0, 0);
        chk("midrst_ready", ir0, 0);
        chk("midrst_index", oidx0, 0);
        reset = 1'b1;
        #1;
        chk("midrst_release_ready", ir0, 1);
        rand_block(blk_b);
        run_block(0, blk_b, zero, 0, 1, fc1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/w_schedule_stream.md
Name: w_schedule_stream

Overview:
- Parametrised SHA-256 message-schedule expander.
- Accepts one 512-bit block as 16 words W0..W15 over a valid/ready handshake.
- Streams W0..W(ROUNDS-1), LANES words per beat, with full output backpressure.
- Sits between block padding/loading and the compression-round pipeline. Replaces the fixed-depth free-running expander with a flow-controlled one that handles configurable lanes and depth.

Parameters:
- LANES, 1, words emitted per output beat; legal values 1, 2, 4, 8.
- ROUNDS, 64, total schedule words emitted per block; must be a multiple of LANES, with 16 <= ROUNDS <= 64.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. One clock; reset is sampled only on the rising edge of clk.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_block  in  512  word i at bits [i*32 +: 32]; word 0 is W0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  beat consumed when out_valid && out_ready.
- out_w  out  LANES*32  lane j at bits [j*32 +: 32] carries W(out_index+j).
- out_index  out  7  schedule index of lane 0: 0, LANES, 2*LANES, ...
- out_last  out  1  high on the final beat of a block (out_index == ROUNDS-LANES).

Behaviour:
- State machine, two states:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=1.
- Reset:
  - While reset is low at a clock edge, the block enters IDLE.
  - out_valid=0, out_last=0, out_index=0, out_w=0, window cleared.
  - in_ready is forced 0 while reset is low and is 1 in the first cycle after reset is released.
- Load:
  - In IDLE, when in_valid is high at edge N, the 16-word window takes win[i]=Wi.
  - The index counter is set to 0 and the state moves to RUN.
  - out_valid is high from cycle N+1, with out_w lanes = W0..W(LANES-1).
  - Latency from block accept to first beat: 1 cycle.
- Output beats:
  - Combinational view: out_w lane j = win[j]; out_index = idx; out_last = (idx == ROUNDS-LANES).
  - When out_valid && !out_ready: hold out_w, out_index and out_last stable; window and idx unchanged.
  - When out_valid && out_ready and not last:
    - Window shifts down by LANES: win[k] <= win[k+LANES] for k < 16-LANES.
    - The top LANES slots receive new words n0..n(LANES-1); idx <= idx+LANES.
- New-word arithmetic (all mod 2^32):
  - n_j = sig1(x[14+j]) + x[9+j] + sig0(x[1+j]) + x[j], where x is the concatenation of win[0..15] followed by n0..n(j-1).
  - For j >= 2, n_j is chained combinationally from n(j-2), etc., within the same cycle.
  - sig0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sig1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Last beat: accepting the beat with out_last high moves the state to IDLE. out_valid drops the next cycle and in_ready rises the next cycle. There is no back-to-back overlap, so the minimum block period is ROUNDS/LANES + 1 cycles.
- in_valid during RUN is ignored; in_block is not sampled and no data is lost, because the upstream holds the block until in_ready.
- out_ready held high continuously gives one beat per cycle with no bubbles.
- Reset asserted mid-block: the block is abandoned immediately, with no partial-block state kept and no further beats. The next block starts at W0.
- Words W0..W15 are emitted unmodified. Expanded words start at index 16.
- For ROUNDS=16, no expansion words are emitted.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), LANES=1, out_ready=1 -> beats W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; 64 beats; out_last only at out_index=63; in_ready high again the cycle after the last beat.
- Same block, LANES=4 -> 16 beats; the beat at out_index=16 carries lanes 0x61626380, 0x000F0000, 0x7DA86405 and the reference W19; the lane stream is identical to the LANES=1 run.
- Random backpressure (out_ready toggled ~50%) on a random block -> the word sequence equals the software SHA-256 schedule; outputs stay stable while stalled; no duplicated or skipped index.
- All-zero block -> all 64 words are 0x00000000; in_valid asserted during RUN with a different block -> ignored, and that block is accepted only once in_ready rises.
- Reset driven low at out_index=20 -> out_valid=0 and in_ready=0 during reset; after release a new block yields out_index=0 with its own W0.
- Two back-to-back blocks with in_valid held high -> first beat of block 2 appears exactly ROUNDS/LANES + 1 cycles after the first beat of block 1.
